// File: rtl/vga_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_wb_pkg
// Brief    : Shared types and constants for the VGA Wishbone request buffer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_wb_pkg;

    localparam int WDOG_W = 8;

    // One posted write: word address [16:1], data, byte selects, space tag
    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        tga;
    } wfifo_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDACK = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_wb_buffer_if
// Brief    : 16-bit Wishbone bus (word address [16:1]) with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_wb_buffer_if;

    logic [15:0] wdat;
    logic [15:0] rdat;
    logic [15:0] adr;
    logic        we;
    logic        tga;
    logic [1:0]  sel;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        output wdat, adr, we, tga, sel, stb, cyc,
        input  rdat, ack
    );

    modport slave (
        input  wdat, adr, we, tga, sel, stb, cyc,
        output rdat, ack
    );

endinterface
`default_nettype wire

// File: rtl/vga_wb_wfifo.sv
`default_nettype none
// ============================================================================
// Module   : vga_wb_wfifo
// Brief    : Posted-write FIFO with registered head entry.
// Revision : 1.0 - initial release
// ============================================================================
module vga_wb_wfifo
    import vga_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire wfifo_entry_t din,
    output wfifo_entry_t      head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    wfifo_entry_t  r_mem [FIFO_DEPTH];
    wfifo_entry_t  r_head;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic          w_push;
    logic          w_pop;

    assign full         = (r_count == (AW+1)'(FIFO_DEPTH));
    assign empty        = (r_count == '0);
    assign w_push       = push & ~full;
    assign w_pop        = pop & ~empty;
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    assign head         = r_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A push landing in the slot that becomes the head bypasses the array
            if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                r_head <= din;
            end else begin
                r_head <= r_mem[w_rd_ptr_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vga_wb_buffer
// Brief    : Posted-write / serialised-read Wishbone buffer in front of the VGA.
// Revision : 1.0 - initial release
// ============================================================================
module vga_wb_buffer
    import vga_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  wire logic      wb_clk_i,
    input  wire logic      wb_rst_i,
    vga_wb_buffer_if.slave  wbs,
    vga_wb_buffer_if.master wbm,
    output logic           busy_o,
    output logic           timeout_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_wbs_ack;
    logic [15:0]         r_wbs_dat;
    logic [15:0]         r_adr;
    logic [15:0]         r_dat;
    logic [1:0]          r_sel;
    logic                r_tga;
    logic                r_we;
    logic                r_stb;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_timeout;
    logic                r_abort;

    logic                w_req;
    logic                w_push;
    logic                w_rd_req;
    logic                w_expire;
    logic                w_abort;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_load_wr;
    logic                w_load_rd;
    logic                w_rd_done;
    logic                w_timeout;
    wfifo_entry_t        w_din;
    wfifo_entry_t        w_head;

    // ~ack keeps a request held through its own ack cycle from being taken twice
    assign w_req    = wbs.stb & wbs.cyc & ~r_wbs_ack;
    assign w_push   = w_req & wbs.we & ~w_full;
    assign w_rd_req = w_req & ~wbs.we;
    assign w_expire = r_stb & ~wbm.ack & (r_wdog == WDOG_W'(TIMEOUT - 1));
    assign w_abort  = r_abort | ~wbs.cyc;
    assign w_din    = '{adr: wbs.adr, dat: wbs.wdat, sel: wbs.sel, tga: wbs.tga};

    vga_wb_wfifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load_wr   = 1'b0;
        w_load_rd   = 1'b0;
        w_rd_done   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = WR;
                    w_load_wr   = 1'b1;
                end else if (w_rd_req) begin
                    w_state_nxt = RD;
                    w_load_rd   = 1'b1;
                end
            end
            WR: begin
                if (wbm.ack || w_expire) begin
                    w_pop       = 1'b1;
                    w_timeout   = ~wbm.ack;
                    w_state_nxt = IDLE;
                end
            end
            RD: begin
                if (wbm.ack || w_expire) begin
                    w_timeout = ~wbm.ack;
                    if (w_abort) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_rd_done   = 1'b1;
                        w_state_nxt = RDACK;
                    end
                end
            end
            RDACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_wbs_ack <= 1'b0;
            r_wbs_dat <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_tga     <= 1'b0;
            r_we      <= 1'b0;
            r_stb     <= 1'b0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wbs_ack <= w_push | w_rd_done;
            r_timeout <= w_timeout;
            if (w_rd_done) begin
                r_wbs_dat <= wbm.ack ? wbm.rdat : 16'hFFFF;
            end
            if (w_load_wr) begin
                r_adr <= w_head.adr;
                r_dat <= w_head.dat;
                r_sel <= w_head.sel;
                r_tga <= w_head.tga;
                r_we  <= 1'b1;
            end else if (w_load_rd) begin
                r_adr <= wbs.adr;
                r_sel <= wbs.sel;
                r_tga <= wbs.tga;
                r_we  <= 1'b0;
            end
            if (w_load_wr || w_load_rd) begin
                r_stb <= 1'b1;
            end else if (r_stb && (wbm.ack || w_expire)) begin
                r_stb <= 1'b0;
            end
            if (w_load_wr || w_load_rd) begin
                r_wdog <= '0;
            end else if (r_stb && !wbm.ack) begin
                r_wdog <= r_wdog + 1'b1;
            end
            // Sticky: the CPU may raise cyc again for a new write before the read drains
            if (r_state != RD) begin
                r_abort <= 1'b0;
            end else if (!wbs.cyc) begin
                r_abort <= 1'b1;
            end
        end
    end

    assign wbs.ack   = r_wbs_ack;
    assign wbs.rdat  = r_wbs_dat;
    assign wbm.adr   = r_adr;
    assign wbm.wdat  = r_dat;
    assign wbm.sel   = r_sel;
    assign wbm.tga   = r_tga;
    assign wbm.we    = r_we;
    assign wbm.stb   = r_stb;
    assign wbm.cyc   = r_stb;
    assign busy_o    = ~w_empty | r_stb;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_vga_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_wb_buffer
// Brief    : Directed self-checking bench for vga_wb_buffer (TIMEOUT = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_wb_buffer;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        tga;
        logic [15:0] rdata;
        int          delay;     // slave ack delay in cycles, -1 = never
        logic [15:0] exp_rdat;
        logic        exp_tmo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic tmo;
    int   n_chk  = 0;
    int   n_fail = 0;

    vga_wb_buffer_if cpu ();
    vga_wb_buffer_if vga ();

    vga_wb_buffer #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs       (cpu),
        .wbm       (vga),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input logic tga);
        cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b1;
        cpu.adr = adr;  cpu.wdat = dat; cpu.sel = sel; cpu.tga = tga;
    endtask

    task automatic cpu_rd(input logic [15:0] adr, input logic [1:0] sel, input logic tga);
        cpu.cyc = 1'b1; cpu.stb = 1'b1; cpu.we = 1'b0;
        cpu.adr = adr;  cpu.wdat = 16'h0000; cpu.sel = sel; cpu.tga = tga;
    endtask

    task automatic cpu_idle();
        cpu.cyc = 1'b0; cpu.stb = 1'b0; cpu.we = 1'b0;
    endtask

    // Wait (bounded) for a master transaction, check it, and ack it at once
    task automatic slave_serve(input string nm, input logic we, input logic [15:0] adr,
                               input logic [15:0] dat, input logic tga, input logic [15:0] rdata);
        int w = 0;
        while (!vga.stb && w < 20) begin
            tick();
            w++;
        end
        chk1({nm, "_stb"}, vga.stb, 1'b1);
        chk1({nm, "_we"}, vga.we, we);
        chk({nm, "_adr"}, vga.adr, adr);
        chk1({nm, "_tga"}, vga.tga, tga);
        if (we) chk({nm, "_dat"}, vga.wdat, dat);
        vga.ack = 1'b1; vga.rdat = rdata;
        tick();
        vga.ack = 1'b0;
        chk1({nm, "_drop"}, vga.stb, 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string p = $sformatf("v%0d", idx);
        if (v.we) cpu_wr(v.adr, v.dat, v.sel, v.tga);
        else      cpu_rd(v.adr, v.sel, v.tga);
        tick();
        if (v.we) begin
            chk1({p, "_wr_ack"}, cpu.ack, 1'b1);
            chk1({p, "_stb_early"}, vga.stb, 1'b0);
            tick();
            cpu_idle();
            chk1({p, "_ack_pulse"}, cpu.ack, 1'b0);
        end
        chk1({p, "_stb"}, vga.stb, 1'b1);
        chk1({p, "_cyc"}, vga.cyc, 1'b1);
        chk1({p, "_we"}, vga.we, v.we);
        chk({p, "_adr"}, vga.adr, v.adr);
        chk({p, "_sel"}, 16'(vga.sel), 16'(v.sel));
        chk1({p, "_tga"}, vga.tga, v.tga);
        if (v.we) chk({p, "_dat"}, vga.wdat, v.dat);
        chk1({p, "_busy"}, busy, 1'b1);
        if (v.delay < 0) begin
            repeat (15) tick();
            chk1({p, "_pre_tmo_stb"}, vga.stb, 1'b1);
            chk1({p, "_pre_tmo"}, tmo, 1'b0);
            tick();
        end else begin
            repeat (v.delay) tick();
            chk1({p, "_stb_held"}, vga.stb, 1'b1);
            vga.ack = 1'b1; vga.rdat = v.rdata;
            tick();
            vga.ack = 1'b0;
        end
        chk1({p, "_tmo"}, tmo, v.exp_tmo);
        chk1({p, "_stb_drop"}, vga.stb, 1'b0);
        chk1({p, "_busy_drop"}, busy, 1'b0);
        if (!v.we) begin
            chk1({p, "_rd_ack"}, cpu.ack, 1'b1);
            chk({p, "_rd_dat"}, cpu.rdat, v.exp_rdat);
            cpu_idle();
        end
        tick();
        chk1({p, "_ack_clear"}, cpu.ack, 1'b0);
        chk1({p, "_tmo_clear"}, tmo, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [6];
        vec_t        pv;
        logic [15:0] fa [5];
        logic [15:0] fd [5];
        int          ack_at [5];
        int          k;

        vecs[0] = '{1'b1, 16'h0010, 16'hA55A, 2'b11, 1'b0, 16'h0000,  2, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 2'b01, 1'b1, 16'h0000,  0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 16'h0020, 16'h0000, 2'b11, 1'b1, 16'h1234,  0, 16'h1234, 1'b0};
        vecs[3] = '{1'b0, 16'h8001, 16'h0000, 2'b10, 1'b0, 16'hBEEF,  3, 16'hBEEF, 1'b0};
        vecs[4] = '{1'b1, 16'h1234, 16'h5678, 2'b10, 1'b0, 16'h0000, -1, 16'h0000, 1'b1};
        vecs[5] = '{1'b0, 16'h00AA, 16'h0000, 2'b11, 1'b0, 16'h5555, -1, 16'hFFFF, 1'b1};
        pv      = '{1'b1, 16'h0300, 16'h3C3C, 2'b11, 1'b1, 16'h0000,  1, 16'h0000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            fa[i]     = 16'h0100 + 16'(i);
            fd[i]     = 16'hC000 + 16'(i * 16'h0111);
            ack_at[i] = -1;
        end

        cpu_idle();
        cpu.adr = '0; cpu.wdat = '0; cpu.sel = '0; cpu.tga = 1'b0;
        vga.ack = 1'b0; vga.rdat = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ack", cpu.ack, 1'b0);
        chk("rst_rdat", cpu.rdat, 16'h0000);
        chk1("rst_stb", vga.stb, 1'b0);
        chk1("rst_cyc", vga.cyc, 1'b0);
        chk("rst_adr", vga.adr, 16'h0000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tmo", tmo, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Full FIFO: four writes fill it, the fifth waits for the first pop
        k = 0;
        cpu_wr(fa[0], fd[0], 2'b11, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            vga.ack = (c == 15);
            tick();
            if (cpu.ack) begin
                if (k < 5) ack_at[k] = c;
                k++;
                if (k < 5) cpu_wr(fa[k], fd[k], 2'b11, 1'b0);
                else       cpu_idle();
            end
            if (c == 14) begin
                chk1("full_hold_stb", vga.stb, 1'b1);
                chk("full_head_adr", vga.adr, fa[0]);
                chk("full_head_dat", vga.wdat, fd[0]);
            end
            if (c == 15) chk1("full_pop_stb", vga.stb, 1'b0);
        end
        vga.ack = 1'b0;
        chk("full_ack0", 16'(ack_at[0]), 16'd1);
        chk("full_ack1", 16'(ack_at[1]), 16'd3);
        chk("full_ack2", 16'(ack_at[2]), 16'd5);
        chk("full_ack3", 16'(ack_at[3]), 16'd7);
        chk("full_ack4", 16'(ack_at[4]), 16'd16);
        cpu_idle();
        slave_serve("full_w1", 1'b1, fa[1], fd[1], 1'b0, 16'h0000);
        slave_serve("full_w2", 1'b1, fa[2], fd[2], 1'b0, 16'h0000);
        slave_serve("full_w3", 1'b1, fa[3], fd[3], 1'b0, 16'h0000);
        slave_serve("full_w4", 1'b1, fa[4], fd[4], 1'b0, 16'h0000);
        tick();
        chk1("full_busy_end", busy, 1'b0);

        // Read queued behind two posted writes
        cpu_wr(16'h0200, 16'h0A0A, 2'b01, 1'b0);
        tick();
        chk1("raw_w0_ack", cpu.ack, 1'b1);
        cpu_wr(16'h0201, 16'h0B0B, 2'b10, 1'b1);
        tick();
        chk1("raw_w1_pend", cpu.ack, 1'b0);
        tick();
        chk1("raw_w1_ack", cpu.ack, 1'b1);
        cpu_rd(16'h0020, 2'b11, 1'b1);
        slave_serve("raw_w0", 1'b1, 16'h0200, 16'h0A0A, 1'b0, 16'h0000);
        chk1("raw_rd_wait0", cpu.ack, 1'b0);
        slave_serve("raw_w1", 1'b1, 16'h0201, 16'h0B0B, 1'b1, 16'h0000);
        chk1("raw_rd_wait1", cpu.ack, 1'b0);
        slave_serve("raw_rd", 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1234);
        chk1("raw_rd_ack", cpu.ack, 1'b1);
        chk("raw_rd_dat", cpu.rdat, 16'h1234);
        cpu_idle();
        tick();
        chk1("raw_ack_clear", cpu.ack, 1'b0);
        chk1("raw_busy_end", busy, 1'b0);

        // Reset with three writes queued and the first in flight
        for (int i = 0; i < 3; i++) begin
            cpu_wr(16'h0400 + 16'(i), 16'h7000 + 16'(i), 2'b11, 1'b0);
            tick();
            chk1("rmid_wr_ack", cpu.ack, 1'b1);
            cpu_idle();
            tick();
        end
        chk1("rmid_stb_before", vga.stb, 1'b1);
        chk1("rmid_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rmid_stb", vga.stb, 1'b0);
        chk1("rmid_cyc", vga.cyc, 1'b0);
        chk1("rmid_busy", busy, 1'b0);
        chk("rmid_rdat", cpu.rdat, 16'h0000);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk1("rmid_stb_after", vga.stb, 1'b0);
        chk1("rmid_busy_after", busy, 1'b0);

        // CPU abandons a read while the master side is still waiting
        cpu_rd(16'h0040, 2'b11, 1'b0);
        tick();
        chk1("abort_stb", vga.stb, 1'b1);
        chk1("abort_we", vga.we, 1'b0);
        cpu_idle();
        repeat (2) tick();
        chk1("abort_stb_held", vga.stb, 1'b1);
        vga.ack = 1'b1; vga.rdat = 16'hCAFE;
        tick();
        vga.ack = 1'b0;
        chk1("abort_no_ack", cpu.ack, 1'b0);
        chk1("abort_stb_drop", vga.stb, 1'b0);
        chk("abort_dat_kept", cpu.rdat, 16'h0000);
        tick();
        chk1("abort_no_ack2", cpu.ack, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        run_vec(6, pv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
